// File: rtl/ps2_byte_receiver_pkg.sv
// rtl/ps2_byte_receiver_pkg.sv - shared PS/2 frame definitions for receiver, transmitter and master SM
// Purpose: state encodings, frame constants, error-bit positions and the frame error helper.
// Ports: none (package).
package ps2_byte_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int PS2_DATA_BITS          = 8;
    localparam int ERR_PARITY             = 0;
    localparam int ERR_STOP               = 1;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic [1:0] frame_errors(input logic [PS2_DATA_BITS-1:0] data,
                                                input logic parity, input logic stop);
        logic [1:0] err;
        err             = 2'b00;
        err[ERR_PARITY] = ~^{data, parity};
        err[ERR_STOP]   = ~stop;
        return err;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchroniser with one-cycle falling-edge detect for a PS/2 line
// Purpose: brings an asynchronous PS/2 line into the CLK domain and flags its falling edges.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset (all flops reset to the idle-high line level)
//   line_i  raw asynchronous line
//   line_o  synchronised line level
//   fall_o  one-cycle pulse when the synchronised line goes 1 -> 0
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic line_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q     <= 1'b1;
            sync_q     <= 1'b1;
            sync_dly_q <= 1'b1;
        end else begin
            meta_q     <= line_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

    assign line_o = sync_q;
    assign fall_o = sync_dly_q & ~sync_q;

endmodule

// File: rtl/ps2_byte_receiver.sv
// rtl/ps2_byte_receiver.sv - PS/2 device-to-host 11-bit frame receiver with timeout
// Purpose: captures start, 8 data bits LSB-first, odd parity and stop from the mouse and
//          presents the byte with a one-cycle ready strobe and parity/stop error flags.
// Ports:
//   CLK              system clock
//   RESET            synchronous active-high reset
//   CLK_MOUSE_IN     raw PS/2 clock line
//   DATA_MOUSE_IN    raw PS/2 data line
//   READ_ENABLE      permits a new frame to start (looked at only in IDLE)
//   BYTE_READ        last received byte
//   BYTE_ERROR_CODE  [0] parity error, [1] stop-bit error
//   BYTE_READY       one-cycle pulse when BYTE_READ/BYTE_ERROR_CODE are new
module ps2_byte_receiver
    import ps2_byte_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CLK_MOUSE_IN,
    input  logic                     DATA_MOUSE_IN,
    input  logic                     READ_ENABLE,
    output logic [PS2_DATA_BITS-1:0] BYTE_READ,
    output logic [1:0]               BYTE_ERROR_CODE,
    output logic                     BYTE_READY
);

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic ps2_clk_sync_unused;
    logic ps2_clk_fall;
    logic ps2_data_sync;
    // The receiver never needs data-line edges; the output exists for the transmitter's use.
    logic ps2_data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .line_i (CLK_MOUSE_IN),
        .line_o (ps2_clk_sync_unused),
        .fall_o (ps2_clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .line_i (DATA_MOUSE_IN),
        .line_o (ps2_data_sync),
        .fall_o (ps2_data_fall_unused)
    );

    ps2_state_e                 state_q,   state_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0]   shift_q,   shift_d;
    logic                       parity_q,  parity_d;
    logic [TIMEOUT_WIDTH-1:0]   timeout_q, timeout_d;
    logic [PS2_DATA_BITS-1:0]   byte_q,    byte_d;
    logic [1:0]                 err_q,     err_d;
    logic                       ready_q,   ready_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            timeout_q <= '0;
            byte_q    <= '0;
            err_q     <= 2'b00;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timeout_q <= timeout_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        timeout_d = '0;
        byte_d    = byte_q;
        err_d     = err_q;
        ready_d   = 1'b0;

        // Expiry takes priority over a coincident fall, so that fall is dropped rather
        // than being mistaken for the start bit of a new frame.
        if (state_q != ST_IDLE && timeout_q == TIMEOUT_LAST) begin
            state_d = ST_IDLE;
        end else begin
            if (state_q != ST_IDLE && !ps2_clk_fall) begin
                timeout_d = timeout_q + TIMEOUT_WIDTH'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (ps2_clk_fall && READ_ENABLE && !ps2_data_sync) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    if (ps2_clk_fall) begin
                        shift_d   = {ps2_data_sync, shift_q[PS2_DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (ps2_clk_fall) begin
                        parity_d = ps2_data_sync;
                        state_d  = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (ps2_clk_fall) begin
                        byte_d  = shift_q;
                        err_d   = frame_errors(shift_q, parity_q, ps2_data_sync);
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign BYTE_READ       = byte_q;
    assign BYTE_ERROR_CODE = err_q;
    assign BYTE_READY      = ready_q;

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// tb/tb_ps2_byte_receiver.sv - self-checking bench for ps2_byte_receiver
module tb_ps2_byte_receiver;

    localparam int TO_CYCLES = 300;
    localparam int HP        = 20;

    logic       clk;
    logic       reset;
    logic       clk_m;
    logic       data_m;
    logic       read_en;
    logic [7:0] byte_read;
    logic [1:0] err_code;
    logic       byte_ready;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    logic       prev_ready = 1'b0;

    ps2_byte_receiver #(
        .TIMEOUT_CYCLES (TO_CYCLES),
        .TIMEOUT_WIDTH  (16)
    ) dut (
        .CLK             (clk),
        .RESET           (reset),
        .CLK_MOUSE_IN    (clk_m),
        .DATA_MOUSE_IN   (data_m),
        .READ_ENABLE     (read_en),
        .BYTE_READ       (byte_read),
        .BYTE_ERROR_CODE (err_code),
        .BYTE_READY      (byte_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    // Drives the first nbits bits of a frame (start first); optionally drops READ_ENABLE
    // right after the start-bit clock pulse.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input int nbits, input int hp, input logic drop_re);
        logic [10:0] bits;
        bits = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            data_m = bits[i];
            cyc(hp);
            clk_m = 1'b0;
            cyc(hp);
            clk_m = 1'b1;
            if (drop_re && i == 0) read_en = 1'b0;
        end
        data_m = 1'b1;
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic [1:0] e);
        exp_q.push_back({e, b});
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Scoreboard side: every ready pulse must be expected, one cycle wide, and match.
    always @(negedge clk) begin
        logic [9:0] e;
        if (byte_ready === 1'b1) begin
            check("ready_width", {31'd0, prev_ready}, 0);
            check("ready_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("byte_read", {24'd0, byte_read}, {24'd0, e[7:0]});
                check("err_code", {30'd0, err_code}, {30'd0, e[9:8]});
            end
        end
        prev_ready = byte_ready;
    end

    initial begin
        reset   = 1'b1;
        clk_m   = 1'b1;
        data_m  = 1'b1;
        read_en = 1'b1;
        cyc(4);
        check("rst_byte", {24'd0, byte_read}, 0);
        check("rst_err", {30'd0, err_code}, 0);
        check("rst_ready", {31'd0, byte_ready}, 0);
        reset = 1'b0;
        cyc(5);

        expect_frame(8'hFA, 2'b00);
        send_frame(8'hFA, odd_par(8'hFA), 1'b1, 11, HP, 1'b0);
        wait_drain("drain_fa", 50);

        expect_frame(8'h08, 2'b01);
        send_frame(8'h08, 1'b1, 1'b1, 11, HP, 1'b0);
        wait_drain("drain_par_err", 50);

        expect_frame(8'h08, 2'b10);
        send_frame(8'h08, 1'b0, 1'b0, 11, HP, 1'b0);
        wait_drain("drain_stop_err", 50);
        cyc(HP);

        send_frame(8'hAA, odd_par(8'hAA), 1'b1, 5, HP, 1'b0);
        cyc(TO_CYCLES + 100);
        check("timeout_hold_byte", {24'd0, byte_read}, 32'h08);
        check("timeout_hold_err", {30'd0, err_code}, 32'h2);
        expect_frame(8'hAA, 2'b00);
        send_frame(8'hAA, odd_par(8'hAA), 1'b1, 11, HP, 1'b0);
        wait_drain("drain_aa", 50);

        read_en = 1'b0;
        send_frame(8'h55, odd_par(8'h55), 1'b1, 11, HP, 1'b0);
        cyc(100);
        check("disabled_hold_byte", {24'd0, byte_read}, 32'hAA);
        read_en = 1'b1;
        cyc(HP);
        expect_frame(8'h55, 2'b00);
        send_frame(8'h55, odd_par(8'h55), 1'b1, 11, HP, 1'b1);
        wait_drain("drain_55_drop_re", 50);
        read_en = 1'b1;
        cyc(HP);

        send_frame(8'h3C, odd_par(8'h3C), 1'b1, 6, HP, 1'b0);
        reset = 1'b1;
        cyc(3);
        check("midrst_byte", {24'd0, byte_read}, 0);
        check("midrst_err", {30'd0, err_code}, 0);
        check("midrst_ready", {31'd0, byte_ready}, 0);
        reset = 1'b0;
        cyc(HP);
        expect_frame(8'h3C, 2'b00);
        send_frame(8'h3C, odd_par(8'h3C), 1'b1, 11, HP, 1'b0);
        wait_drain("drain_3c", 50);
        cyc(HP);

        expect_frame(8'h08, 2'b00);
        expect_frame(8'h01, 2'b00);
        expect_frame(8'h02, 2'b00);
        send_frame(8'h08, odd_par(8'h08), 1'b1, 11, 1, 1'b0);
        send_frame(8'h01, odd_par(8'h01), 1'b1, 11, 1, 1'b0);
        send_frame(8'h02, odd_par(8'h02), 1'b1, 11, 1, 1'b0);
        wait_drain("drain_b2b", 50);
        check("final_byte", {24'd0, byte_read}, 32'h02);

        cyc(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
